// File: rtl/bcd_lab_pkg.sv
// bcd_lab_pkg: shared entry-state codes and BCD digit constants for the BCD adder lab
package bcd_lab_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        READY   = 2'b10
    } entry_state_t;
endpackage

// File: rtl/bcd_operand_entry_debounce.sv
// btn_debounce: input synchronizer, stability counter and one-cycle press pulse for a push-button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable;
    logic [CW-1:0]          cnt;
    // Synchronize, count disagreement cycles, toggle the stable level once it has held long enough
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            press  <= 1'b0;
            if (sync_q[SYNC_STAGES-1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                stable <= ~stable;
                cnt    <= '0;
                press  <= ~stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: debounced, range-checked entry of BCD operands A, B and carry-in (range check enabled by BCD_RANGE_CHECK_EN)
module bcd_operand_entry
    import bcd_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    input  logic [BCD_W-1:0] sw,
    input  logic             sw_carry,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [BCD_W-1:0] a,
    output logic [BCD_W-1:0] b,
    output logic             carry_in,
    output logic             operands_valid,
    output logic             entry_error,
    output logic [1:0]       entry_state
);
    entry_state_t                     state, state_n;
    logic [SYNC_STAGES-1:0][BCD_W:0]  sw_pipe;
    logic [BCD_W-1:0]                 sw_s, a_n, b_n;
    logic                             carry_s, c_n, err_n, legal, load_press, clear_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_load (
        .clock_100Mhz(clock_100Mhz), .reset(reset), .btn(btn_load), .press(load_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clear (
        .clock_100Mhz(clock_100Mhz), .reset(reset), .btn(btn_clear), .press(clear_press)
    );

    assign sw_s    = sw_pipe[SYNC_STAGES-1][BCD_W-1:0];
    assign carry_s = sw_pipe[SYNC_STAGES-1][BCD_W];
`ifdef BCD_RANGE_CHECK_EN
    assign legal = sw_s <= BCD_MAX;
`else
    assign legal = 1'b1;
`endif
    assign operands_valid = state == READY;
    assign entry_state    = state;

    // Synchronize the digit and carry switches with the same depth as the buttons
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) sw_pipe <= '0;
        else       sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], {sw_carry, sw}};
    end

    // Next state and operand updates; clear overrides a coincident load
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        c_n     = carry_in;
        err_n   = entry_error;
        if (clear_press) begin
            state_n = ENTER_A;
            a_n     = '0;
            b_n     = '0;
            c_n     = 1'b0;
            err_n   = 1'b0;
        end else begin
            case (state)
                ENTER_A, READY: if (load_press) begin
                    a_n     = legal ? sw_s : a;
                    err_n   = ~legal;
                    state_n = legal ? ENTER_B : state;
                end
                ENTER_B: if (load_press) begin
                    b_n     = legal ? sw_s : b;
                    c_n     = legal ? carry_s : carry_in;
                    err_n   = ~legal;
                    state_n = legal ? READY : ENTER_B;
                end
                default: state_n = ENTER_A;
            endcase
        end
    end

    // State and operand registers
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state       <= ENTER_A;
            a           <= '0;
            b           <= '0;
            carry_in    <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            state       <= state_n;
            a           <= a_n;
            b           <= b_n;
            carry_in    <= c_n;
            entry_error <= err_n;
        end
    end
endmodule

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
Upstream operand-entry stage for the Basys 3 BCD adder lab. Debounces the board push-buttons and synchronizes the slide switches. Walks the user through entering operand A, then operand B with carry-in. Presents registered, range-checked `a`, `b` and `carry_in` plus a valid flag to the BCD adder/display stage.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button change is accepted (10 ms at 100 MHz); must be >= 2.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers for switches and buttons; must be >= 2.

Ports:
- clock_100Mhz  input  1  100 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- sw  input  4  raw slide-switch BCD digit.
- sw_carry  input  1  raw slide switch for carry-in.
- btn_load  input  1  raw push-button; captures the current digit.
- btn_clear  input  1  raw push-button; restarts entry.
- a  output  4  registered operand A.
- b  output  4  registered operand B.
- carry_in  output  1  registered carry, captured together with B.
- operands_valid  output  1  high while A, B and carry are complete (READY state).
- entry_error  output  1  sticky flag: last load attempt was rejected.
- entry_state  output  2  current state code, for LED indication.

Behaviour:
- Reset (async, active-high): a=0, b=0, carry_in=0, operands_valid=0, entry_error=0, state=ENTER_A (entry_state=2'b00). Debounce counters and synchronizers clear; the stable level of each button is 0.
- Synchronizers: sw, sw_carry, btn_load and btn_clear each pass through SYNC_STAGES flops. No other use of the raw inputs is allowed.
- Debounce, per button:
  - Counter increments while the synchronized level differs from the stable level.
  - Counter clears on any cycle where they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - press = one-cycle pulse when the stable level goes 0->1. Releases produce no pulse.
- Latency: raw button held high, first sampled at edge N -> press pulse high in cycle N+SYNC_STAGES+DEBOUNCE_CYCLES. The operand/state update is visible one cycle later.
- Digit check: the digit is legal if synchronized sw <= 9.
- States (entry_state encoding): ENTER_A=00, ENTER_B=01, READY=10. Code 11 is unused and returns to ENTER_A.
- ENTER_A on load press:
  - Legal: a<=sw, entry_error<=0, go to ENTER_B.
  - Illegal: entry_error<=1, stay; a unchanged.
- ENTER_B on load press:
  - Legal: b<=sw, carry_in<=sw_carry, entry_error<=0, go to READY.
  - Illegal: entry_error<=1, stay.
- READY:
  - operands_valid=1 (Moore, decoded from state).
  - Load press starts a new entry with the same rules as ENTER_A: legal -> a<=sw, go to ENTER_B, operands_valid drops; illegal -> entry_error<=1, stay in READY with operands held.
- Clear press, any state: a<=0, b<=0, carry_in<=0, entry_error<=0, go to ENTER_A.
- Clear and load pulse in the same cycle: clear wins; the load is discarded.
- In ENTER_A/ENTER_B, a and b keep their last values and operands_valid=0, so downstream must qualify with operands_valid.
- Reset mid-debounce discards the pending press. Reset mid-entry discards partial operands.

Optional Feature:
- BCD_RANGE_CHECK_EN defined: the digit check above applies; entry_error is functional.
- Not defined: every sw value 0-15 is accepted and loaded unchanged; entry_error is tied to 0. Used for exercising the adder's hex-display path.

Decomposition:
- Shared package bcd_lab_pkg:
  - entry state enum/localparams (ENTER_A, ENTER_B, READY);
  - BCD_MAX=9;
  - BCD digit width 4.
- One sub-module, btn_debounce (synchronizer + counter + rising-edge pulse), parameterised by DEBOUNCE_CYCLES and SYNC_STAGES. It is instantiated twice (load, clear).

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, macro defined unless noted):
- Reset, then sw=3, press load; sw=5, sw_carry=1, press load -> a=3, b=5, carry_in=1, operands_valid=1, entry_state=10.
- btn_load glitches high 3 cycles then low -> no press pulse, state and operands unchanged. A clean hold -> update appears exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after the first sampled high.
- In ENTER_A, sw=12, press load -> entry_error=1, stays ENTER_A, a=0. Then sw=7, press load -> entry_error=0, a=7, ENTER_B.
- In READY, debounced clear and load pulses coincide -> ENTER_A, a=b=carry_in=0, operands_valid=0.
- Reset asserted mid-ENTER_B and mid-debounce -> all outputs 0 immediately (asynchronous), no stale press pulse after release.
- Macro undefined: sw=15, two loads -> a=15, b=15, entry_error stays 0, operands_valid=1.
